row_line_buffer: RTL

Double-buffered row prefetcher between the framebuffer RAM read port (port B, 2048×16 RGB565) and the two `pixel_split` instances. While the matrix scanner shifts out the current row pair from the front bank, the block fetches the next top/bottom row pair into the back bank. Banks flip at row latch. This decouples RAM timing from pixel-clock timing and lets the scanner see a stable row for every brightness sub-frame.

---
 rtl/linebuf_pkg.sv | 20 ++
 rtl/row_line_buffer_line_bank.sv | 39 +++
 rtl/row_line_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/linebuf_pkg.sv
// Shared constants, fill FSM encoding and framebuffer address packing for the row line buffer.
package linebuf_pkg;
  localparam int COLUMNS   = 64;
  localparam int COL_WIDTH = 6;
  localparam int ROW_WIDTH = 4;
  localparam int ADDR_W    = 1 + ROW_WIDTH + COL_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_t;

  // Top half lives in the lower half of the framebuffer, bottom half in the upper.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic                 half,
                                                  input logic [ROW_WIDTH-1:0] row,
                                                  input logic [COL_WIDTH-1:0] col);
    return {half, row, col};
  endfunction
endpackage

// File: rtl/row_line_buffer_line_bank.sv
// Two-bank row storage: one write port into the back bank, one registered top/bottom read of the front bank.
// Address MSB is the bank select; write address is {bank, half, col}, read address is {bank, col}.
module line_bank #(
  parameter int COLUMNS     = 64,
  parameter int COL_WIDTH   = 6,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic [COL_WIDTH+1:0]   i_wr_addr,
  input  logic [PIXEL_WIDTH-1:0] i_wr_dat,
  input  logic [COL_WIDTH:0]     i_rd_addr,
  output logic [PIXEL_WIDTH-1:0] o_rd_top,
  output logic [PIXEL_WIDTH-1:0] o_rd_bottom
);
  logic [PIXEL_WIDTH-1:0] r_mem_top [2*COLUMNS];
  logic [PIXEL_WIDTH-1:0] r_mem_bot [2*COLUMNS];
  logic [COL_WIDTH:0]     w_wr_idx;
  logic                   w_wr_half;

  assign w_wr_idx  = {i_wr_addr[COL_WIDTH+1], i_wr_addr[COL_WIDTH-1:0]};
  assign w_wr_half = i_wr_addr[COL_WIDTH];

  always_ff @(posedge clk_in) begin
    if (i_wr_en && !w_wr_half) r_mem_top[w_wr_idx] <= i_wr_dat;
    if (i_wr_en &&  w_wr_half) r_mem_bot[w_wr_idx] <= i_wr_dat;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      o_rd_top    <= '0;
      o_rd_bottom <= '0;
    end else begin
      o_rd_top    <= r_mem_top[i_rd_addr];
      o_rd_bottom <= r_mem_bot[i_rd_addr];
    end
  end
endmodule

// File: rtl/row_line_buffer.sv
// Double-buffered row prefetcher: fills the back bank from framebuffer RAM while the scanner reads the front bank.
// Optional LINEBUF_UNDERRUN_BLANK_EN: an underrunning swap blanks both outputs until the next good swap.
module row_line_buffer
  import linebuf_pkg::*;
#(
  parameter int COLUMNS     = linebuf_pkg::COLUMNS,
  parameter int COL_WIDTH   = linebuf_pkg::COL_WIDTH,
  parameter int ROW_WIDTH   = linebuf_pkg::ROW_WIDTH,
  parameter int ADDR_WIDTH  = 11,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   row_start,
  input  logic [ROW_WIDTH-1:0]   row_address,
  input  logic                   swap,
  input  logic [COL_WIDTH-1:0]   column_address,
  output logic [ADDR_WIDTH-1:0]  ram_address,
  output logic                   ram_clk_enable,
  input  logic [PIXEL_WIDTH-1:0] ram_data_in,
  output logic [PIXEL_WIDTH-1:0] rgb565_top,
  output logic [PIXEL_WIDTH-1:0] rgb565_bottom,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   underrun
);
  fill_state_t            r_state, w_state_nxt;
  logic [COL_WIDTH:0]     r_k;
  logic [ROW_WIDTH-1:0]   r_row;
  logic                   r_bank_sel;
  logic                   r_back_ready;
  logic                   r_underrun;
  logic                   r_cap_vld;
  logic [COL_WIDTH:0]     r_cap_addr;
  logic                   w_swap_ok;
  logic [PIXEL_WIDTH-1:0] w_rd_top, w_rd_bottom;

  always_comb begin
    w_state_nxt    = r_state;
    ram_clk_enable = 1'b0;
    ram_address    = '0;
    fill_busy      = 1'b1;
    fill_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        fill_busy = 1'b0;
        if (row_start) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        ram_clk_enable = 1'b1;
        ram_address    = ADDR_WIDTH'(pack_addr(r_k[0], r_row, r_k[COL_WIDTH:1]));
        if (&r_k) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        fill_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A swap landing on the fill_done cycle still gets the freshly completed bank.
  assign w_swap_ok = r_back_ready || fill_done;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_row        <= '0;
      r_bank_sel   <= 1'b0;
      r_back_ready <= 1'b0;
      r_underrun   <= 1'b0;
      r_cap_vld    <= 1'b0;
      r_cap_addr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cap_vld  <= ram_clk_enable;
      r_cap_addr <= {r_k[0], r_k[COL_WIDTH:1]};
      if (r_state == ST_IDLE && row_start) begin
        r_row <= row_address;
        r_k   <= '0;
      end else if (r_state == ST_READ) begin
        r_k <= r_k + 1'b1;
      end
      if (swap && w_swap_ok)                    r_back_ready <= 1'b0;
      else if (r_state == ST_DRAIN)             r_back_ready <= 1'b1;
      else if (r_state == ST_IDLE && row_start) r_back_ready <= 1'b0;
      if (swap) begin
        if (w_swap_ok) r_bank_sel <= ~r_bank_sel;
        else           r_underrun <= 1'b1;
      end
    end
  end

  line_bank #(
    .COLUMNS    (COLUMNS),
    .COL_WIDTH  (COL_WIDTH),
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_bank (
    .clk_in     (clk_in),
    .reset      (reset),
    .i_wr_en    (r_cap_vld),
    .i_wr_addr  ({~r_bank_sel, r_cap_addr}),
    .i_wr_dat   (ram_data_in),
    .i_rd_addr  ({r_bank_sel, column_address}),
    .o_rd_top   (w_rd_top),
    .o_rd_bottom(w_rd_bottom)
  );

  assign underrun = r_underrun;

`ifdef LINEBUF_UNDERRUN_BLANK_EN
  logic r_blank;
  always_ff @(posedge clk_in) begin
    if (reset)     r_blank <= 1'b0;
    else if (swap) r_blank <= ~w_swap_ok;
  end
  assign rgb565_top    = r_blank ? '0 : w_rd_top;
  assign rgb565_bottom = r_blank ? '0 : w_rd_bottom;
`else
  assign rgb565_top    = w_rd_top;
  assign rgb565_bottom = w_rd_bottom;
`endif
endmodule
